// File: rtl/mux_pkg.sv
// Shared constants and FSM state type for the round-robin mux select arbiter.
package mux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    localparam int CNT_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the requesters, the arbiter and the downstream 4:1 mux.
interface mux_sel_arbiter_if;
    import mux_pkg::*;

    logic [NUM_CH-1:0] req;
    logic              ack;
    logic [SEL_W-1:0]  sel;
    logic [NUM_CH-1:0] gnt;
    logic              valid;
    logic              timeout;

    modport slave (
        input  req,
        input  ack,
        output sel,
        output gnt,
        output valid,
        output timeout
    );

    modport master (
        output req,
        output ack,
        input  sel,
        input  gnt,
        input  valid,
        input  timeout
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first set request at or above ptr_i, wrapping.
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [SEL_W-1:0]  ptr_i,
    output logic [SEL_W-1:0]  winner_o,
    output logic              any_o
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        winner_o = ptr_i;
        any_o    = 1'b0;
        idx      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // Index arithmetic wraps naturally because NUM_CH == 2**SEL_W.
            idx = ptr_i + SEL_W'(i);
            if (!any_o && req_i[idx]) begin
                winner_o = idx;
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select, with ack handshake and grant timeout.
module mux_sel_arbiter #(
    parameter int NUM_CH  = mux_pkg::NUM_CH,
    parameter int SEL_W   = mux_pkg::SEL_W,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_sel_arbiter_if.slave bus
);
    import mux_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              to_q, to_d;
    logic              grant_end;

    logic [SEL_W-1:0]  pick_ptr;
    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;

    // While granted, the search for the follow-on winner starts just past the
    // current one, so it is ready the same cycle the grant ends.
    assign pick_ptr = (state_q == GRANT) ? (sel_q + SEL_W'(1)) : ptr_q;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_pick (
        .req_i    (bus.req),
        .ptr_i    (pick_ptr),
        .winner_o (pick_idx),
        .any_o    (pick_any)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        to_d      = 1'b0;
        grant_end = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    gnt_d   = NUM_CH'(1) << pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                // ack wins over a timeout landing in the same cycle.
                if (bus.ack) begin
                    grant_end = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    grant_end = 1'b1;
                    to_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (grant_end) begin
                    ptr_d = sel_q + SEL_W'(1);
                    cnt_d = '0;
                    if (pick_any) begin
                        sel_d = pick_idx;
                        gnt_d = NUM_CH'(1) << pick_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.gnt     = gnt_q;
    assign bus.valid   = (state_q == GRANT);
    assign bus.timeout = to_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: behavioural round-robin model plus literal checkpoints.
module tb_mux_sel_arbiter;

    localparam int TMO = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mux_sel_arbiter_if bus();

    mux_sel_arbiter #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: whole grants as an owner index plus a wait count.
    int m_busy = 0;
    int m_win  = 0;
    int m_ptr  = 0;
    int m_wait = 0;
    int m_to   = 0;

    function automatic int rr(input logic [3:0] r, input int from);
        for (int k = 0; k < 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int w;
        bit ended;
        if (!rst_n) begin
            m_busy = 0; m_win = 0; m_ptr = 0; m_wait = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (m_busy == 0) begin
                w = rr(bus.req, m_ptr);
                if (w >= 0) begin
                    m_busy = 1; m_win = w; m_wait = 0;
                end
            end else begin
                ended = 0;
                if (bus.ack) ended = 1;
                else begin
                    m_wait++;
                    if (m_wait == TMO) begin
                        ended = 1; m_to = 1;
                    end
                end
                if (ended) begin
                    m_ptr = (m_win + 1) % 4;
                    w = rr(bus.req, m_ptr);
                    if (w >= 0) begin
                        m_win = w; m_wait = 0;
                    end else begin
                        m_busy = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_valid", 32'(bus.valid), 32'(m_busy));
        chk("model_sel", 32'(bus.sel), 32'(m_win));
        chk("model_gnt", 32'(bus.gnt), (m_busy != 0) ? (32'd1 << m_win) : 32'd0);
        chk("model_timeout", 32'(bus.timeout), 32'(m_to));
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(input string tag, input logic v, input logic [1:0] s,
                       input logic [3:0] g, input logic t);
        chk({tag, "_valid"}, 32'(bus.valid), 32'(v));
        chk({tag, "_sel"}, 32'(bus.sel), 32'(s));
        chk({tag, "_gnt"}, 32'(bus.gnt), 32'(g));
        chk({tag, "_timeout"}, 32'(bus.timeout), 32'(t));
    endtask

    initial begin
        bus.req = 4'b0000;
        bus.ack = 1'b0;
        rst_n   = 1'b0;
        cyc(2);
        lit("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        rst_n = 1'b1;
        cyc(1);

        // single request on ch2, then ack returns to idle with sel held
        bus.req = 4'b0100;
        cyc(1);
        lit("single_gnt", 1'b1, 2'd2, 4'b0100, 1'b0);
        bus.req = 4'b0000; bus.ack = 1'b1;
        cyc(1);
        lit("single_ack", 1'b0, 2'd2, 4'b0000, 1'b0);
        bus.ack = 1'b0;

        // all requesting, ack every cycle: 0,1,2,3,0 without bubbles
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        bus.req = 4'b1111;
        cyc(1);
        lit("rr0", 1'b1, 2'd0, 4'b0001, 1'b0);
        bus.ack = 1'b1;
        cyc(1); lit("rr1", 1'b1, 2'd1, 4'b0010, 1'b0);
        cyc(1); lit("rr2", 1'b1, 2'd2, 4'b0100, 1'b0);
        cyc(1); lit("rr3", 1'b1, 2'd3, 4'b1000, 1'b0);
        cyc(1); lit("rr4", 1'b1, 2'd0, 4'b0001, 1'b0);
        bus.req = 4'b0000;
        cyc(1); lit("rr_idle", 1'b0, 2'd0, 4'b0000, 1'b0);
        bus.ack = 1'b0;

        // request drops mid-grant: grant holds until ack
        bus.req = 4'b0010;
        cyc(1); lit("drop_gnt", 1'b1, 2'd1, 4'b0010, 1'b0);
        bus.req = 4'b0000;
        cyc(1); lit("drop_hold", 1'b1, 2'd1, 4'b0010, 1'b0);
        bus.ack = 1'b1;
        cyc(1); lit("drop_ack", 1'b0, 2'd1, 4'b0000, 1'b0);
        bus.ack = 1'b0;

        // timeout on ch0 with nothing else pending
        bus.req = 4'b0001;
        cyc(1); lit("to_c1", 1'b1, 2'd0, 4'b0001, 1'b0);
        bus.req = 4'b0000;
        cyc(1); lit("to_c2", 1'b1, 2'd0, 4'b0001, 1'b0);
        cyc(1); lit("to_c3", 1'b1, 2'd0, 4'b0001, 1'b0);
        cyc(1); lit("to_pulse", 1'b0, 2'd0, 4'b0000, 1'b1);
        cyc(1); lit("to_after", 1'b0, 2'd0, 4'b0000, 1'b0);

        // timeout with request still up re-grants; ack on the last cycle suppresses the pulse
        bus.req = 4'b0010;
        cyc(3); lit("to2_c3", 1'b1, 2'd1, 4'b0010, 1'b0);
        cyc(1); lit("to2_regrant", 1'b1, 2'd1, 4'b0010, 1'b1);
        cyc(2); lit("to2_last", 1'b1, 2'd1, 4'b0010, 1'b0);
        bus.ack = 1'b1; bus.req = 4'b0000;
        cyc(1); lit("to2_ackwins", 1'b0, 2'd1, 4'b0000, 1'b0);
        bus.ack = 1'b0;

        // asynchronous reset mid-grant on ch3
        bus.req = 4'b1000;
        cyc(1); lit("rst_pre", 1'b1, 2'd3, 4'b1000, 1'b0);
        rst_n = 1'b0;
        #1;
        lit("rst_async", 1'b0, 2'd0, 4'b0000, 1'b0);
        cyc(1);
        rst_n = 1'b1;
        bus.req = 4'b1001;
        cyc(1); lit("rst_post", 1'b1, 2'd0, 4'b0001, 1'b0);
        bus.req = 4'b0000; bus.ack = 1'b1;
        cyc(1); lit("rst_idle", 1'b0, 2'd0, 4'b0000, 1'b0);
        bus.ack = 1'b0;

        // sole requester is re-granted back-to-back
        bus.req = 4'b0100;
        cyc(1); lit("sole_g1", 1'b1, 2'd2, 4'b0100, 1'b0);
        bus.ack = 1'b1;
        cyc(1); lit("sole_g2", 1'b1, 2'd2, 4'b0100, 1'b0);
        cyc(1); lit("sole_g3", 1'b1, 2'd2, 4'b0100, 1'b0);
        bus.req = 4'b0000;
        cyc(1); lit("sole_idle", 1'b0, 2'd2, 4'b0000, 1'b0);
        bus.ack = 1'b0;

        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_sel_arbiter.md
MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of request channels, fixed to 4 in this revision.
REQ-002 SHALL have parameter SEL_W, default 2: select width, equal to log2(NUM_CH).
REQ-003 SHALL have parameter TIMEOUT, default 15: maximum cycles a grant waits for ack, legal range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req, input, NUM_CH bits: per-channel request; bit i is channel i (d0..d3 of the downstream 4:1 3-bit mux).
REQ-007 SHALL have port ack, input, 1 bit: downstream consumer has taken the current mux output.
REQ-008 SHALL have port sel, output, SEL_W bits: registered select, driving the downstream 4:1 mux select directly.
REQ-009 SHALL have port gnt, output, NUM_CH bits: registered one-hot grant, consistent with sel.
REQ-010 SHALL have port valid, output, 1 bit: high while a grant is active.
REQ-011 SHALL have port timeout, output, 1 bit: single-cycle pulse when a grant is dropped without ack.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (valid=0, gnt=0) and GRANT (valid=1, gnt one-hot).
REQ-013 In IDLE with req!=0, SHALL pick a winner, load sel and gnt, and enter GRANT; valid rises 1 cycle after the req sample.
REQ-014 In IDLE with req==0, SHALL stay in IDLE; sel holds its last value.
REQ-015 SHALL pick the winner round-robin: the first set req bit searching upward from ptr, wrapping 3->0.
REQ-016 ptr SHALL be updated to (winner+1) mod 4 whenever a grant ends, by ack or by timeout.
REQ-017 In GRANT, sel and gnt SHALL stay stable until the grant ends; a request that deasserts mid-grant does not cancel the grant.
REQ-018 On ack in GRANT with req (sampled the same cycle) nonzero, SHALL grant the next winner in the next cycle with valid held high (back-to-back, no bubble).
REQ-019 On ack in GRANT with req==0, SHALL return to IDLE in the next cycle.
REQ-020 The next winner's search SHALL start from (current winner+1); a re-asserted current channel wins again only if it is the sole requester.
REQ-021 ack in IDLE SHALL be ignored.
REQ-022 SHALL run an 8-bit wait counter: cleared on entry to every grant, incremented each GRANT cycle without ack.
REQ-023 When the counter reaches TIMEOUT with no ack, SHALL pulse timeout for 1 cycle and end the grant, following the REQ-018/019 path as if acked.
REQ-024 ack in the same cycle the counter reaches TIMEOUT SHALL take precedence; no timeout pulse.

Reset
REQ-025 While rst_n=0: state=IDLE, sel=0, gnt=0, valid=0, timeout=0, ptr=0, counter=0, applied asynchronously.
REQ-026 Reset asserted mid-grant SHALL drop the grant immediately; after release the first grant searches from channel 0.
REQ-027 Reset deassertion SHALL be synchronised externally; this block has no synchroniser.

Structure
REQ-028 The shared package mux_pkg SHALL hold NUM_CH, SEL_W, and the FSM state typedef (IDLE, GRANT).
REQ-029 The round-robin search SHALL be a combinational sub-module rr_pick, with inputs req and ptr and outputs winner index and any flag.
REQ-030 All outputs SHALL be registered; no combinational path from req or ack to any output.

Verification
REQ-031 Reset, then req=0100 -> 1 cycle later valid=1, sel=2, gnt=0100; ack -> next cycle valid=0.
REQ-032 req=1111 held, ack every cycle -> sel sequence 0,1,2,3,0, valid high throughout.
REQ-033 Grant on ch1, req drops to 0000 mid-grant -> sel=1 and valid held until ack.
REQ-034 TIMEOUT=3, grant ch0, no ack -> timeout pulses exactly on the 3rd wait cycle, then next grant or IDLE; ack on that cycle -> no pulse.
REQ-035 rst_n low mid-grant on ch3 -> all outputs 0 immediately; after release, req=1001 -> sel=0.
REQ-036 Only ch2 requesting, ack each grant -> ch2 re-granted back-to-back, sel=2 continuously.
